// File: rtl/traffic_light_monitor.sv
// Passive monitor for traffic-light controller outputs: phase tracking, dwell timing, round counting, error flags.
// Optional dwell-range checking is enabled by defining LIGHT_MON_DWELL_CHK_EN.
module traffic_light_monitor #(
  parameter int unsigned DW        = 8,
  parameter int unsigned CW        = 16,
  parameter int unsigned MIN_DWELL = 2,
  parameter int unsigned MAX_DWELL = 200
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          green,
  input  logic          yellow,
  input  logic          red,
  input  logic          err_clr,
  output logic [1:0]    phase,
  output logic [DW-1:0] dwell_cnt,
  output logic [DW-1:0] last_dwell,
  output logic          last_vld,
  output logic [CW-1:0] cycle_cnt,
  output logic          err_code,
  output logic          err_seq,
  output logic          err_dwell,
  output logic          err_sticky
);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    PH_G = 2'd1,
    PH_Y = 2'd2,
    PH_R = 2'd3
  } phase_t;

  phase_t state;
  phase_t obs;
  logic   legal;
  logic   order_ok;
  logic   bad_prev;
  logic   stay;
  logic   change;
  logic   code_ev;
  logic   seq_ev;
  logic   dwell_ev;

  always_comb begin
    obs   = SYNC;
    legal = 1'b1;
    case ({green, yellow, red})
      3'b100:  obs = PH_G;
      3'b010:  obs = PH_Y;
      3'b001:  obs = PH_R;
      default: legal = 1'b0;
    endcase
    order_ok = (state == PH_G && obs == PH_Y) ||
               (state == PH_Y && obs == PH_R) ||
               (state == PH_R && obs == PH_G);
    stay    = legal && (state != SYNC) && (obs == state);
    change  = legal && (state != SYNC) && (obs != state);
    code_ev = !legal && !bad_prev;
    seq_ev  = change && !order_ok;
  end

`ifdef LIGHT_MON_DWELL_CHK_EN
  // Dwell can only exceed MAX_DWELL by passing through MAX_DWELL+1 in-phase, where it
  // already pulsed, so the exit check needs only the lower bound.
  always_comb begin
    dwell_ev = (stay && dwell_cnt == DW'(MAX_DWELL)) ||
               (change && dwell_cnt < DW'(MIN_DWELL));
  end
`else
  assign dwell_ev = 1'b0;
`endif

  assign phase = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= SYNC;
      dwell_cnt  <= '0;
      last_dwell <= '0;
      last_vld   <= 1'b0;
      cycle_cnt  <= '0;
      err_code   <= 1'b0;
      err_seq    <= 1'b0;
      err_dwell  <= 1'b0;
      err_sticky <= 1'b0;
      bad_prev   <= 1'b0;
    end else begin
      last_vld  <= 1'b0;
      err_code  <= code_ev;
      err_seq   <= seq_ev;
      err_dwell <= dwell_ev;
      bad_prev  <= !legal;
      if (!legal) begin
        state     <= SYNC;
        dwell_cnt <= '0;
      end else if (state == SYNC) begin
        state     <= obs;
        dwell_cnt <= DW'(1);
      end else if (stay) begin
        if (dwell_cnt != '1)
          dwell_cnt <= dwell_cnt + DW'(1);
      end else begin
        last_dwell <= dwell_cnt;
        last_vld   <= 1'b1;
        state      <= obs;
        dwell_cnt  <= DW'(1);
        if (state == PH_R && obs == PH_G)
          cycle_cnt <= cycle_cnt + CW'(1);
      end
      if (code_ev || seq_ev || dwell_ev)
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor; dwell-check expectations follow LIGHT_MON_DWELL_CHK_EN.
module tb_traffic_light_monitor;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
`ifdef LIGHT_MON_DWELL_CHK_EN
  localparam int unsigned DCHK = 1;
`else
  localparam int unsigned DCHK = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          green = 1'b0;
  logic          yellow = 1'b0;
  logic          red = 1'b0;
  logic          err_clr = 1'b0;
  logic [1:0]    phase;
  logic [DW-1:0] dwell_cnt;
  logic [DW-1:0] last_dwell;
  logic          last_vld;
  logic [CW-1:0] cycle_cnt;
  logic          err_code;
  logic          err_seq;
  logic          err_dwell;
  logic          err_sticky;

  int unsigned checks = 0;
  int unsigned errors = 0;

  traffic_light_monitor #(.DW(DW), .CW(CW), .MIN_DWELL(2), .MAX_DWELL(200)) dut (
    .clk(clk), .rstn(rstn), .green(green), .yellow(yellow), .red(red),
    .err_clr(err_clr), .phase(phase), .dwell_cnt(dwell_cnt),
    .last_dwell(last_dwell), .last_vld(last_vld), .cycle_cnt(cycle_cnt),
    .err_code(err_code), .err_seq(err_seq), .err_dwell(err_dwell),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply a light code for one edge, then sample just after it.
  task automatic step(input logic [2:0] gyr);
    {green, yellow, red} = gyr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    step(3'b000);
    step(3'b000);
    chk("rst_phase", phase, 0);
    chk("rst_dwell", dwell_cnt, 0);
    chk("rst_last", last_dwell, 0);
    chk("rst_vld", last_vld, 0);
    chk("rst_cyc", cycle_cnt, 0);
    chk("rst_errs", {err_code, err_seq, err_dwell, err_sticky}, 0);
    rstn = 1'b1;

    // Legal round G3 Y2 R4 G1
    step(3'b100); chk("g1_phase", phase, 1); chk("g1_dwell", dwell_cnt, 1);
    step(3'b100);
    step(3'b100); chk("g3_dwell", dwell_cnt, 3);
    step(3'b010); chk("y_phase", phase, 2); chk("gy_vld", last_vld, 1); chk("gy_last", last_dwell, 3);
    step(3'b010); chk("y2_vld", last_vld, 0); chk("y2_dwell", dwell_cnt, 2);
    step(3'b001); chk("r_phase", phase, 3); chk("yr_vld", last_vld, 1); chk("yr_last", last_dwell, 2);
    step(3'b001);
    step(3'b001);
    step(3'b001); chk("r4_dwell", dwell_cnt, 4);
    step(3'b100); chk("rg_phase", phase, 1); chk("rg_last", last_dwell, 4); chk("rg_cyc", cycle_cnt, 1);
    chk("round_errs", {err_code, err_seq, err_dwell, err_sticky}, 0);

    // Illegal order G->R, sticky clear, clear vs new error
    step(3'b100);
    step(3'b001); chk("gr_seq", err_seq, 1); chk("gr_phase", phase, 3); chk("gr_sticky", err_sticky, 1);
    chk("gr_cyc", cycle_cnt, 1);
    err_clr = 1'b1;
    step(3'b001); chk("clr_seq", err_seq, 0); chk("clr_sticky", err_sticky, 0);
    err_clr = 1'b0;
    step(3'b100); chk("rg2_cyc", cycle_cnt, 2); chk("rg2_seq", err_seq, 0);
    err_clr = 1'b1;
    step(3'b001); chk("clrwin_seq", err_seq, 1); chk("clrwin_sticky", err_sticky, 1);
    err_clr = 1'b0;

    // Illegal code 110 held three cycles, then resync on Y
    step(3'b100); chk("rg3_cyc", cycle_cnt, 3);
    step(3'b110); chk("bad1_code", err_code, 1); chk("bad1_phase", phase, 0);
    chk("bad1_dwell", dwell_cnt, 0); chk("bad1_vld", last_vld, 0);
    step(3'b110); chk("bad2_code", err_code, 0);
    step(3'b110); chk("bad3_code", err_code, 0); chk("bad3_phase", phase, 0);
    step(3'b010); chk("sync_phase", phase, 2); chk("sync_dwell", dwell_cnt, 1);
    chk("sync_seq", err_seq, 0); chk("sync_vld", last_vld, 0); chk("sync_cyc", cycle_cnt, 3);

    // Long G hold: saturation and over-max pulse
    step(3'b001);
    step(3'b100); chk("rg4_cyc", cycle_cnt, 4);
    for (int i = 2; i <= 300; i++) begin
      step(3'b100);
      if (i == 200) chk("hold200_dwell", err_dwell, 0);
      if (i == 201) chk("hold201_dwell", err_dwell, DCHK);
      if (i == 202) chk("hold202_dwell", err_dwell, 0);
    end
    chk("sat_dwell", dwell_cnt, 255);
    step(3'b010); chk("sat_last", last_dwell, 255); chk("sat_exit_dwell", err_dwell, 0);
    chk("sat_phase", phase, 2);

    // Short Y exit
    step(3'b001); chk("short_dwell", err_dwell, DCHK); chk("short_last", last_dwell, 1);

    // Reset mid-R with dwell 50, cycle_cnt 7
    for (int k = 0; k < 3; k++) begin
      step(3'b100);
      step(3'b010);
      step(3'b001);
    end
    for (int i = 2; i <= 50; i++) step(3'b001);
    chk("pre_dwell", dwell_cnt, 50);
    chk("pre_cyc", cycle_cnt, 7);
    rstn = 1'b0;
    step(3'b001);
    chk("mid_phase", phase, 0); chk("mid_dwell", dwell_cnt, 0);
    chk("mid_last", last_dwell, 0); chk("mid_vld", last_vld, 0);
    chk("mid_cyc", cycle_cnt, 0);
    chk("mid_errs", {err_code, err_seq, err_dwell, err_sticky}, 0);
    rstn = 1'b1;
    step(3'b001); chk("post_phase", phase, 3); chk("post_dwell", dwell_cnt, 1);
    chk("post_vld", last_vld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the far end of the traffic-light controller outputs (green/yellow/red).
- Decodes the light code every cycle and tracks the phase with a state machine.
- Flags illegal codes and illegal phase orders, measures per-phase dwell time in cycles, and counts completed G->Y->R->G rounds.
- Used in system sim and as an on-chip health monitor beside the controller.

Parameters:
- DW, 8, width of the dwell counters in bits.
- CW, 16, width of the completed-round counter in bits.
- MIN_DWELL, 2, minimum legal dwell per phase in cycles (used only with the optional feature).
- MAX_DWELL, 200, maximum legal dwell per phase in cycles (used only with the optional feature); must be < 2^DW-1.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- green  in  1  observed green light
- yellow  in  1  observed yellow light
- red  in  1  observed red light
- err_clr  in  1  clears err_sticky
- phase  out  2  tracked phase: 0=SYNC, 1=G, 2=Y, 3=R
- dwell_cnt  out  DW  consecutive cycles in the current phase, saturating
- last_dwell  out  DW  dwell of the phase just exited
- last_vld  out  1  1-cycle pulse when last_dwell is updated
- cycle_cnt  out  CW  completed legal R->G rounds, wraps
- err_code  out  1  1-cycle pulse: illegal light code
- err_seq  out  1  1-cycle pulse: illegal phase order
- err_dwell  out  1  1-cycle pulse: dwell out of range
- err_sticky  out  1  OR of all errors, held until cleared

Behaviour:
- All outputs are registered. Inputs sampled at edge k are reflected in the outputs after edge k (1-cycle latency).
- Reset (rstn=0 at an edge): phase=0, dwell_cnt=0, last_dwell=0, last_vld=0, cycle_cnt=0, all err_*=0, err_sticky=0. Reset mid-operation aborts the current phase with no last_vld pulse.
- Code {green,yellow,red}: legal codes are 100=G, 010=Y, 001=R. Any other code (000, 110, 011, 101, 111) is illegal.
- Illegal code: err_code=1, phase->SYNC, dwell_cnt=0, no last_vld pulse.
- In SYNC, a legal code X: phase->X, dwell_cnt=1, no err_seq, no last_vld pulse, cycle_cnt unchanged.
- In phase P with legal code equal to P: dwell_cnt increments and saturates at 2^DW-1.
- In phase P with a different legal code Q:
  - last_dwell<=dwell_cnt, last_vld=1, phase->Q, dwell_cnt=1.
  - Legal orders are G->Y, Y->R and R->G. Any other order pulses err_seq=1, and the phase still moves to Q to resync.
  - A legal R->G increments cycle_cnt, which wraps from 2^CW-1 to 0.
- Any err_code, err_seq or err_dwell pulse sets err_sticky. err_clr clears it.
- If err_clr and a new error occur in the same cycle, the error wins and err_sticky stays 1.
- Error pulses last exactly one cycle per event and do not repeat while the condition persists. Each new illegal-code entry from a legal phase counts as one event. In SYNC with a continued illegal code, err_code pulses only on the first cycle.

Optional Feature:
- Macro: LIGHT_MON_DWELL_CHK_EN.
- Defined: on every phase exit from G/Y/R to another legal phase, err_dwell=1 if the exiting dwell_cnt < MIN_DWELL or > MAX_DWELL. It is also asserted once, at the edge where dwell_cnt reaches MAX_DWELL+1 while still in the phase; the exit check for that same phase is then suppressed.
- Exit to SYNC via an illegal code does not perform a dwell check.
- Not defined: err_dwell is tied to 0 and no comparator logic is present.

Test Plan:
- Reset, then drive G x3, Y x2, R x4, G x1 -> phase reads 1,2,3,1. last_vld pulses with last_dwell=3, 2, 4. cycle_cnt=1. All err_*=0.
- Drive G x2 then R -> err_seq pulses for 1 cycle, phase=3, err_sticky=1. Pulse err_clr -> err_sticky=0. Assert err_clr together with a new G->R error -> err_sticky stays 1.
- From phase G, drive 110 for 3 cycles -> a single err_code pulse, phase=0, dwell_cnt=0. Then drive 010 -> phase=2, dwell_cnt=1, no err_seq, no last_vld.
- With DW=8, hold G for 300 cycles -> dwell_cnt saturates at 255. Then drive Y -> last_dwell=255.
- With LIGHT_MON_DWELL_CHK_EN: Y x1 then R -> err_dwell at the exit. Hold G for 201 cycles -> err_dwell at dwell 201, with no second pulse at exit. Without the macro, both cases give err_dwell=0.
- Assert rstn=0 mid-R with dwell 50 and cycle_cnt=7 -> every output returns to its reset value at the next edge. Then drive R -> phase=3, dwell_cnt=1.
